// File: rtl/alioth_irq_pkg.sv
// Shared definitions for the interrupt gateway: register map offsets, ID width and the CLAIM read layout.
package alioth_irq_pkg;

    localparam int IRQ_ID_W = 5;

    localparam logic [31:0] IRQ_CTRL_OFS      = 32'h00;
    localparam logic [31:0] IRQ_ENABLE_OFS    = 32'h04;
    localparam logic [31:0] IRQ_PENDING_OFS   = 32'h08;
    localparam logic [31:0] IRQ_TYPE_OFS      = 32'h0C;
    localparam logic [31:0] IRQ_CLAIM_OFS     = 32'h10;
    localparam logic [31:0] IRQ_INSERVICE_OFS = 32'h14;

    typedef struct packed {
        logic                valid;
        logic [25:0]         rsvd;
        logic [IRQ_ID_W-1:0] id;
    } claim_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: reports whether any bit is set and the highest set index (0 when none).
module irq_prio_enc
    import alioth_irq_pkg::*;
#(
    parameter int NUM_IRQ = 11
) (
    input  logic [NUM_IRQ-1:0]  i_vec,
    output logic                o_any,
    output logic [IRQ_ID_W-1:0] o_idx
);

    // Ascending scan so the last (highest) set bit overrides lower ones.
    always_comb begin
        o_any = |i_vec;
        o_idx = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (i_vec[i]) o_idx = IRQ_ID_W'(i);
        end
    end

endmodule

// File: rtl/irq_gateway.sv
// Interrupt gateway: source capture, masking, fixed-priority arbitration and APB claim/complete interface.
// Define IRQ_GATEWAY_SYNC_EN to put a 2-flop synchroniser on every source line.
module irq_gateway
    import alioth_irq_pkg::*;
#(
    parameter int NUM_IRQ        = 11,
    parameter int APB_ADDR_WIDTH = 12,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_IRQ-1:0]        irq_src_i,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic                      PWRITE,
    input  logic [DATA_WIDTH-1:0]     PWDATA,
    output logic [DATA_WIDTH-1:0]     PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    output logic                      irq_o,
    output logic [IRQ_ID_W-1:0]       irq_id_o
);

    logic                r_gen;
    logic [NUM_IRQ-1:0]  r_enable;
    logic [NUM_IRQ-1:0]  r_pending;
    logic [NUM_IRQ-1:0]  r_type;
    logic [NUM_IRQ-1:0]  r_inservice;
    logic [NUM_IRQ-1:0]  r_src_q;
    logic                r_irq;
    logic [IRQ_ID_W-1:0] r_irq_id;

    logic [NUM_IRQ-1:0]  w_src;
    logic [NUM_IRQ-1:0]  w_cand;
    logic [NUM_IRQ-1:0]  w_claim_mask;
    logic [NUM_IRQ-1:0]  w_complete_mask;
    logic [NUM_IRQ-1:0]  w_w1c_mask;
    logic [NUM_IRQ-1:0]  w_edge_set;
    logic [NUM_IRQ-1:0]  w_edge_pend;
    logic [NUM_IRQ-1:0]  w_pending_nxt;
    logic                w_any;
    logic [IRQ_ID_W-1:0] w_win;
    logic [31:0]         w_addr;
    logic                w_access, w_wr, w_rd, w_mapped, w_claim;
    logic                w_sel_ctrl, w_sel_enable, w_sel_pending;
    logic                w_sel_type, w_sel_claim, w_sel_inservice;
    logic [31:0]         w_rdata;
    claim_t              w_claim_rd;
    logic                w_unused;

`ifdef IRQ_GATEWAY_SYNC_EN
    logic [NUM_IRQ-1:0] r_sync1, r_sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= irq_src_i;
            r_sync2 <= r_sync1;
        end
    end

    assign w_src = r_sync2;
`else
    assign w_src = irq_src_i;
`endif

    assign w_addr   = 32'(PADDR);
    assign w_access = PSEL & PENABLE;
    assign w_wr     = w_access & PWRITE;
    assign w_rd     = w_access & ~PWRITE;

    assign w_sel_ctrl      = (w_addr == IRQ_CTRL_OFS);
    assign w_sel_enable    = (w_addr == IRQ_ENABLE_OFS);
    assign w_sel_pending   = (w_addr == IRQ_PENDING_OFS);
    assign w_sel_type      = (w_addr == IRQ_TYPE_OFS);
    assign w_sel_claim     = (w_addr == IRQ_CLAIM_OFS);
    assign w_sel_inservice = (w_addr == IRQ_INSERVICE_OFS);
    assign w_mapped = w_sel_ctrl | w_sel_enable | w_sel_pending |
                      w_sel_type | w_sel_claim | w_sel_inservice;

    // A claim only has side effects when a request is actually being presented.
    assign w_claim         = w_rd & w_sel_claim & r_irq;
    assign w_claim_mask    = w_claim ? (NUM_IRQ'(1) << r_irq_id) : '0;
    assign w_complete_mask = (w_wr & w_sel_claim) ? (NUM_IRQ'(1) << PWDATA[IRQ_ID_W-1:0]) : '0;
    assign w_w1c_mask      = (w_wr & w_sel_pending) ? (PWDATA[NUM_IRQ-1:0] & r_type) : '0;

    // Edge bits: a new edge beats any same-cycle clear; level bits simply follow the line unless in service.
    assign w_edge_set    = w_src & ~r_src_q & r_type;
    assign w_edge_pend   = w_edge_set | (r_pending & ~(w_w1c_mask | w_claim_mask));
    assign w_pending_nxt = (r_type & w_edge_pend) | (~r_type & w_src & ~r_inservice);

    assign w_cand = r_pending & r_enable & ~r_inservice & {NUM_IRQ{r_gen}};

    irq_prio_enc #(
        .NUM_IRQ (NUM_IRQ)
    ) u_prio_enc (
        .i_vec (w_cand),
        .o_any (w_any),
        .o_idx (w_win)
    );

    always_comb begin
        w_claim_rd       = '0;
        w_claim_rd.valid = r_irq;
        w_claim_rd.id    = r_irq ? r_irq_id : '0;
        w_rdata          = '0;
        if (w_sel_ctrl)      w_rdata = {31'b0, r_gen};
        if (w_sel_enable)    w_rdata = 32'(r_enable);
        if (w_sel_pending)   w_rdata = 32'(r_pending);
        if (w_sel_type)      w_rdata = 32'(r_type);
        if (w_sel_claim)     w_rdata = w_claim_rd;
        if (w_sel_inservice) w_rdata = 32'(r_inservice);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gen       <= 1'b0;
            r_enable    <= '0;
            r_pending   <= '0;
            r_type      <= '0;
            r_inservice <= '0;
            r_src_q     <= '0;
            r_irq       <= 1'b0;
            r_irq_id    <= '0;
        end else begin
            r_src_q     <= w_src;
            r_pending   <= w_pending_nxt;
            r_inservice <= (r_inservice | w_claim_mask) & ~w_complete_mask;
            r_irq       <= w_any;
            r_irq_id    <= w_win;
            if (w_wr && w_sel_ctrl)   r_gen    <= PWDATA[0];
            if (w_wr && w_sel_enable) r_enable <= PWDATA[NUM_IRQ-1:0];
            if (w_wr && w_sel_type)   r_type   <= PWDATA[NUM_IRQ-1:0];
        end
    end

    assign PRDATA   = DATA_WIDTH'(w_rdata);
    assign PREADY   = 1'b1;
    assign PSLVERR  = w_access & ~w_mapped;
    assign irq_o    = r_irq;
    assign irq_id_o = r_irq_id;

    assign w_unused = ^PWDATA[DATA_WIDTH-1:NUM_IRQ];

endmodule

// File: tb/tb_irq_gateway.sv
// Directed self-checking bench for irq_gateway; expected values are hand-derived constants.
// Builds with or without IRQ_GATEWAY_SYNC_EN; the source-to-irq latency adapts accordingly.
module tb_irq_gateway;

`ifdef IRQ_GATEWAY_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    localparam logic [11:0] A_CTRL = 12'h00;
    localparam logic [11:0] A_EN   = 12'h04;
    localparam logic [11:0] A_PEND = 12'h08;
    localparam logic [11:0] A_TYPE = 12'h0C;
    localparam logic [11:0] A_CLM  = 12'h10;
    localparam logic [11:0] A_INS  = 12'h14;
    localparam logic [11:0] A_BAD  = 12'h18;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] irq_src_i = '0;
    logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [11:0] PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR, irq_o;
    logic [4:0]  irq_id_o;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] rd;
    logic        err;

    irq_gateway dut (
        .clk       (clk),
        .rst       (rst),
        .irq_src_i (irq_src_i),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PADDR     (PADDR),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR),
        .irq_o     (irq_o),
        .irq_id_o  (irq_id_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One APB transfer: setup phase, then access phase sampled mid-cycle, commit on the following edge.
    task automatic applyStimulus(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                                 output logic [31:0] rdata, output logic slverr);
        @(negedge clk);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
        @(negedge clk);
        PENABLE = 1'b1;
        #1;
        rdata  = PRDATA;
        slverr = PSLVERR;
        @(posedge clk);
        #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic writeReg(input logic [11:0] addr, input logic [31:0] wdata);
        logic [31:0] d;
        logic        e;
        applyStimulus(1'b1, addr, wdata, d, e);
    endtask

    task automatic readReg(input logic [11:0] addr, output logic [31:0] data);
        logic e;
        applyStimulus(1'b0, addr, 32'h0, data, e);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulseSrc(input logic [10:0] mask);
        @(negedge clk);
        irq_src_i = irq_src_i | mask;
        @(posedge clk);
        #1;
        irq_src_i = irq_src_i & ~mask;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        waitCycles(3);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("reset irq_o", 32'(irq_o), 32'h0);
        checkOutput("reset irq_id", 32'(irq_id_o), 32'h0);
        readReg(A_PEND, rd); checkOutput("reset PENDING", rd, 32'h0);
        readReg(A_INS, rd);  checkOutput("reset INSERVICE", rd, 32'h0);

        // Edge path and source-to-irq latency.
        writeReg(A_TYPE, 32'h7FF);
        writeReg(A_EN, 32'h001);
        writeReg(A_CTRL, 32'h1);
        @(negedge clk);
        irq_src_i[0] = 1'b1;
        for (int k = 1; k <= LAT; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) irq_src_i[0] = 1'b0;
            if (k == LAT - 1) checkOutput("latency early irq_o", 32'(irq_o), 32'h0);
        end
        checkOutput("edge irq_o", 32'(irq_o), 32'h1);
        checkOutput("edge irq_id", 32'(irq_id_o), 32'h0);
        readReg(A_CLM, rd); checkOutput("edge claim", rd, 32'h8000_0000);
        waitCycles(1);
        checkOutput("edge irq_o after claim", 32'(irq_o), 32'h0);
        writeReg(A_CLM, 32'h0);

        // Priority and nesting.
        writeReg(A_EN, 32'h7FF);
        pulseSrc(11'h208);
        waitCycles(LAT);
        readReg(A_CLM, rd); checkOutput("nest claim 9", rd, 32'h8000_0009);
        readReg(A_CLM, rd); checkOutput("nest claim 3", rd, 32'h8000_0003);
        readReg(A_CLM, rd); checkOutput("nest claim none", rd, 32'h0);
        readReg(A_INS, rd); checkOutput("nest INSERVICE", rd, 32'h208);
        writeReg(A_CLM, 32'h9);
        readReg(A_INS, rd); checkOutput("complete 9 INSERVICE", rd, 32'h008);

        // Level path.
        writeReg(A_TYPE, 32'h0);
        @(negedge clk);
        irq_src_i[7] = 1'b1;
        waitCycles(LAT + 1);
        checkOutput("level irq_id", 32'(irq_id_o), 32'h7);
        readReg(A_CLM, rd); checkOutput("level claim", rd, 32'h8000_0007);
        waitCycles(2);
        checkOutput("level irq_o in service", 32'(irq_o), 32'h0);
        writeReg(A_CLM, 32'h7);
        waitCycles(1);
        checkOutput("level repend early", 32'(irq_o), 32'h0);
        waitCycles(1);
        checkOutput("level repend irq_o", 32'(irq_o), 32'h1);
        checkOutput("level repend irq_id", 32'(irq_id_o), 32'h7);
        writeReg(A_PEND, 32'h80);
        readReg(A_PEND, rd); checkOutput("level W1C ignored", rd, 32'h80);
        @(negedge clk);
        irq_src_i[7] = 1'b0;
        waitCycles(LAT + 1);
        readReg(A_PEND, rd); checkOutput("level drop PENDING", rd, 32'h0);

        // Set/clear collision on an edge bit.
        writeReg(A_TYPE, 32'h7FF);
        pulseSrc(11'h004);
        waitCycles(LAT);
        readReg(A_PEND, rd); checkOutput("edge2 PENDING", rd, 32'h004);
        writeReg(A_PEND, 32'h004);
        readReg(A_PEND, rd); checkOutput("W1C clears", rd, 32'h0);
        pulseSrc(11'h004);
        waitCycles(LAT);
        @(negedge clk);
        if (LAT == 4) irq_src_i[2] = 1'b1;
        @(negedge clk);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = A_PEND; PWDATA = 32'h004;
        @(negedge clk);
        PENABLE = 1'b1;
        irq_src_i[2] = 1'b1;
        @(posedge clk);
        #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        irq_src_i[2] = 1'b0;
        readReg(A_PEND, rd); checkOutput("collision PENDING", rd, 32'h004);

        // Masking and errors.
        writeReg(A_CTRL, 32'h0);
        waitCycles(1);
        checkOutput("GEN off irq_o", 32'(irq_o), 32'h0);
        readReg(A_PEND, rd); checkOutput("GEN off PENDING kept", rd, 32'h004);
        readReg(A_CLM, rd); checkOutput("claim when idle", rd, 32'h0);
        applyStimulus(1'b0, A_BAD, 32'h0, rd, err);
        checkOutput("unmapped PRDATA", rd, 32'h0);
        checkOutput("unmapped PSLVERR", 32'(err), 32'h1);
        applyStimulus(1'b0, A_PEND, 32'h0, rd, err);
        checkOutput("mapped PSLVERR", 32'(err), 32'h0);
        writeReg(A_EN, 32'hFFFF_FFFF);
        readReg(A_EN, rd); checkOutput("ENABLE upper bits", rd, 32'h7FF);
        applyStimulus(1'b1, A_BAD, 32'h0, rd, err);
        readReg(A_EN, rd); checkOutput("unmapped write no effect", rd, 32'h7FF);
        writeReg(A_CLM, 32'h4);
        readReg(A_INS, rd); checkOutput("complete not in service", rd, 32'h008);

        // Reset in the middle of servicing.
        writeReg(A_CTRL, 32'h1);
        pulseSrc(11'h020);
        waitCycles(LAT);
        checkOutput("pre-reset irq_id", 32'(irq_id_o), 32'h5);
        readReg(A_CLM, rd); checkOutput("pre-reset claim", rd, 32'h8000_0005);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("post-reset irq_o", 32'(irq_o), 32'h0);
        checkOutput("post-reset irq_id", 32'(irq_id_o), 32'h0);
        readReg(A_CTRL, rd); checkOutput("post-reset CTRL", rd, 32'h0);
        readReg(A_EN, rd);   checkOutput("post-reset ENABLE", rd, 32'h0);
        readReg(A_PEND, rd); checkOutput("post-reset PENDING", rd, 32'h0);
        readReg(A_TYPE, rd); checkOutput("post-reset TYPE", rd, 32'h0);
        readReg(A_INS, rd);  checkOutput("post-reset INSERVICE", rd, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
